// File: rtl/ir_tx_if.sv
// Request/status bundle for the NEC infrared transmitter.
// The master side issues requests; the slave side is the transmitter.
interface ir_tx_if;
    logic [15:0] ir_code;
    logic        send;
    logic        send_repeat;
    logic        busy;
    logic        done;
    logic        ir_env;
    logic        ir_tx;

    modport master (
        output ir_code, send, send_repeat,
        input  busy, done, ir_env, ir_tx
    );

    modport slave (
        input  ir_code, send, send_repeat,
        output busy, done, ir_env, ir_tx
    );
endinterface

// File: rtl/ir_tx.sv
// NEC infrared transmitter: full frames and repeat codes, with an envelope output and a carrier-modulated LED drive.
// Assumes UNIT_CYCLES >= 2 and CARRIER_HIGH <= CARRIER_DIV.
module ir_tx #(
    parameter int UNIT_CYCLES  = 15188,
    parameter int CARRIER_DIV  = 711,
    parameter int CARRIER_HIGH = 237,
    parameter int GAP_UNITS    = 16
) (
    input  logic    clk27,
    input  logic    reset_n,
    ir_tx_if.slave  bus
);

    localparam int CW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int KW        = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int UW        = $clog2(MAX_UNITS + 1);

    localparam logic [CW-1:0] CYC_LAST   = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_PENULT = CW'(UNIT_CYCLES - 2);
    localparam logic [KW-1:0] CAR_LAST   = KW'(CARRIER_DIV - 1);
    localparam logic [KW:0]   CAR_HIGH   = (KW+1)'(CARRIER_HIGH);
    localparam logic [UW-1:0] GAP_LAST   = UW'(GAP_UNITS - 1);
    localparam logic          MARK_TX    = (CARRIER_HIGH > 0);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cyc_cnt;
    logic [UW-1:0]   unit_cnt;
    logic [4:0]      bit_cnt;
    logic [31:0]     shift;
    logic [KW-1:0]   car_cnt;
    logic            is_repeat;

    logic [UW-1:0]   state_units;
    logic            state_end;
    logic [KW-1:0]   car_next;
    logic            car_high_next;

    // Length of the current state in units; the bit space length comes from the bit being sent.
    always_comb begin
        state_units = UW'(1);
        case (state)
            LEAD_MARK:  state_units = UW'(16);
            LEAD_SPACE: state_units = is_repeat ? UW'(4) : UW'(8);
            BIT_SPACE:  state_units = shift[0] ? UW'(3) : UW'(1);
            GAP:        state_units = UW'(GAP_UNITS);
            default:    state_units = UW'(1);
        endcase
        state_end     = (cyc_cnt == CYC_LAST) && (unit_cnt == state_units - UW'(1));
        car_next      = (car_cnt == CAR_LAST) ? '0 : car_cnt + KW'(1);
        car_high_next = ({1'b0, car_next} < CAR_HIGH);
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            unit_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            car_cnt     <= '0;
            is_repeat   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.ir_env  <= 1'b0;
            bus.ir_tx   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.send || bus.send_repeat) begin
                    state      <= LEAD_MARK;
                    is_repeat  <= !bus.send;
                    if (bus.send)
                        shift <= {~bus.ir_code[7:0], bus.ir_code[7:0],
                                  ~bus.ir_code[15:8], bus.ir_code[15:8]};
                    cyc_cnt    <= '0;
                    unit_cnt   <= '0;
                    bit_cnt    <= '0;
                    car_cnt    <= '0;
                    bus.busy   <= 1'b1;
                    bus.ir_env <= 1'b1;
                    bus.ir_tx  <= MARK_TX;
                end
            end else if (state_end) begin
                // Every state entry restarts the unit, cycle and carrier counters.
                cyc_cnt  <= '0;
                unit_cnt <= '0;
                car_cnt  <= '0;
                case (state)
                    LEAD_MARK: begin
                        state      <= LEAD_SPACE;
                        bus.ir_env <= 1'b0;
                        bus.ir_tx  <= 1'b0;
                    end
                    LEAD_SPACE: begin
                        state      <= is_repeat ? STOP_MARK : BIT_MARK;
                        bus.ir_env <= 1'b1;
                        bus.ir_tx  <= MARK_TX;
                    end
                    BIT_MARK: begin
                        state      <= BIT_SPACE;
                        bus.ir_env <= 1'b0;
                        bus.ir_tx  <= 1'b0;
                    end
                    BIT_SPACE: begin
                        shift      <= shift >> 1;
                        bit_cnt    <= bit_cnt + 5'd1;
                        state      <= (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
                        bus.ir_env <= 1'b1;
                        bus.ir_tx  <= MARK_TX;
                    end
                    STOP_MARK: begin
                        state      <= GAP;
                        bus.ir_env <= 1'b0;
                        bus.ir_tx  <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        bus.busy   <= 1'b0;
                        bus.ir_env <= 1'b0;
                        bus.ir_tx  <= 1'b0;
                    end
                endcase
            end else begin
                cyc_cnt   <= (cyc_cnt == CYC_LAST) ? '0 : cyc_cnt + CW'(1);
                if (cyc_cnt == CYC_LAST)
                    unit_cnt <= unit_cnt + UW'(1);
                car_cnt   <= car_next;
                bus.ir_tx <= bus.ir_env && car_high_next;
                // Raise done one cycle early so it is visible during the final gap cycle.
                if (state == GAP && unit_cnt == GAP_LAST && cyc_cnt == CYC_PENULT)
                    bus.done <= 1'b1;
            end
        end
    end

endmodule
